// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared Canny pipeline types and default geometry
package canny_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    localparam int DEF_WIDTH       = 640;
    localparam int DEF_DEPTH       = 512;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int IDX_W           = 10;

endpackage

// File: rtl/canny_nms_stage_pos_counter.sv
// rtl/canny_nms_stage_pos_counter.sv - window position counters, border flag and last-position detect
module nms_pos_counter
    import canny_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    output logic [IDX_W-1:0] col_o,
    output logic [IDX_W-1:0] row_o,
    output logic             border_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(DEPTH - KERNEL_SIZE);
    localparam logic [IDX_W-1:0] COL_MIN  = IDX_W'(KERNEL_SIZE - 1);

    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (adv_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o    = col_q;
    assign row_o    = row_q;
    // Left columns lack a full window from this line; first/last rows sit on the image edge.
    assign border_o = (col_q < COL_MIN) || (row_q == '0) || (row_q == ROW_LAST);
    assign last_o   = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/canny_nms_stage.sv
// rtl/canny_nms_stage.sv - two-stage Canny non-maximum suppression over a 3x3 magnitude window
module canny_nms_stage
    import canny_pkg::*;
#(
    parameter int                    WIDTH       = DEF_WIDTH,
    parameter int                    DEPTH       = DEF_DEPTH,
    parameter int                    KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] LOW_FLOOR   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  win_valid,
    input  logic [1:0]            dir_in,
    input  logic [DATA_WIDTH-1:0] p11,
    input  logic [DATA_WIDTH-1:0] p12,
    input  logic [DATA_WIDTH-1:0] p13,
    input  logic [DATA_WIDTH-1:0] p21,
    input  logic [DATA_WIDTH-1:0] p22,
    input  logic [DATA_WIDTH-1:0] p23,
    input  logic [DATA_WIDTH-1:0] p31,
    input  logic [DATA_WIDTH-1:0] p32,
    input  logic [DATA_WIDTH-1:0] p33,
    output logic                  nms_valid,
    output logic [DATA_WIDTH-1:0] nms_data,
    output logic [IDX_W-1:0]      col_idx,
    output logic [IDX_W-1:0]      row_idx,
    output logic                  frame_done
);

    function automatic logic [DATA_WIDTH-1:0] floor_f(input logic [DATA_WIDTH-1:0] x);
        return (x < LOW_FLOOR) ? '0 : x;
    endfunction

    logic [IDX_W-1:0] pos_col, pos_row;
    logic             pos_border, pos_last;

    nms_pos_counter #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .KERNEL_SIZE(KERNEL_SIZE)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (win_valid),
        .col_o   (pos_col),
        .row_o   (pos_row),
        .border_o(pos_border),
        .last_o  (pos_last)
    );

    logic [DATA_WIDTH-1:0] nbr_a, nbr_b;

    always_comb begin
        nbr_a = p21;
        nbr_b = p23;
        case (dir_e'(dir_in))
            DIR_0:   begin nbr_a = p21; nbr_b = p23; end
            DIR_45:  begin nbr_a = p31; nbr_b = p13; end
            DIR_90:  begin nbr_a = p12; nbr_b = p32; end
            DIR_135: begin nbr_a = p11; nbr_b = p33; end
            default: begin nbr_a = p21; nbr_b = p23; end
        endcase
    end

    logic                  s1_valid_q, s1_border_q, s1_last_q;
    logic [DATA_WIDTH-1:0] c_q, a_q, b_q;
    logic [IDX_W-1:0]      s1_col_q, s1_row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_last_q   <= 1'b0;
            c_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
        end else begin
            s1_valid_q <= win_valid;
            if (win_valid) begin
                c_q         <= floor_f(p22);
                a_q         <= floor_f(nbr_a);
                b_q         <= floor_f(nbr_b);
                s1_col_q    <= pos_col;
                s1_row_q    <= pos_row;
                s1_border_q <= pos_border;
                s1_last_q   <= pos_last;
            end
        end
    end

    // >= on one side, > on the other, so a flat ridge keeps exactly one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nms_valid  <= 1'b0;
            nms_data   <= '0;
            col_idx    <= '0;
            row_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            nms_valid  <= s1_valid_q;
            frame_done <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                nms_data <= (!s1_border_q && (c_q >= a_q) && (c_q > b_q)) ? c_q : '0;
                col_idx  <= s1_col_q;
                row_idx  <= s1_row_q;
            end
        end
    end

endmodule

// File: tb/tb_canny_nms_stage.sv
// tb/tb_canny_nms_stage.sv - self-checking bench for canny_nms_stage
module tb_canny_nms_stage;

    localparam int W       = 16;
    localparam int D       = 10;
    localparam int K       = 3;
    localparam int DW      = 16;
    localparam int FLOOR   = 20;
    localparam int LASTROW = D - K;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          win_valid = 1'b0;
    logic [1:0]    dir_in = 2'd0;
    logic [DW-1:0] w [9];
    logic          nms_valid, frame_done;
    logic [DW-1:0] nms_data;
    logic [9:0]    col_idx, row_idx;

    always #5 clk = ~clk;

    canny_nms_stage #(
        .WIDTH(W), .DEPTH(D), .KERNEL_SIZE(K), .DATA_WIDTH(DW), .LOW_FLOOR(16'(FLOOR))
    ) dut (
        .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .dir_in(dir_in),
        .p11(w[0]), .p12(w[1]), .p13(w[2]),
        .p21(w[3]), .p22(w[4]), .p23(w[5]),
        .p31(w[6]), .p32(w[7]), .p33(w[8]),
        .nms_valid(nms_valid), .nms_data(nms_data),
        .col_idx(col_idx), .row_idx(row_idx), .frame_done(frame_done)
    );

    typedef struct {
        logic        v;
        logic [15:0] data;
        int          col;
        int          row;
        logic        done;
    } exp_t;

    typedef struct {
        int          row;
        int          col;
        logic [1:0]  dir;
        logic [15:0] p [9];
        logic [15:0] exp;
    } vec_t;

    exp_t          e1, e2, ezero;
    int            bcol, brow;
    int            n_vec = 0;
    int            n_err = 0;
    int            obs_valid, obs_done;
    logic [15:0]   z [9];
    logic [15:0]   rw [9];
    vec_t          vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fl(input logic [15:0] x);
        return (x < 16'(FLOOR)) ? 16'd0 : x;
    endfunction

    function automatic logic [15:0] model(input logic [1:0] d, input logic [15:0] p [9], input bit border);
        int ia, ib;
        logic [15:0] c, a, b;
        case (d)
            2'd0:    begin ia = 3; ib = 5; end
            2'd1:    begin ia = 6; ib = 2; end
            2'd2:    begin ia = 1; ib = 7; end
            default: begin ia = 0; ib = 8; end
        endcase
        c = fl(p[4]);
        a = fl(p[ia]);
        b = fl(p[ib]);
        if (!border && c >= a && c > b) return c;
        return 16'd0;
    endfunction

    // Called at a falling edge: check what the DUT shows now, then drive the next input.
    task automatic step(input bit v, input logic [1:0] d, input logic [15:0] p [9]);
        exp_t n;
        bit   border;
        chk("valid", nms_valid, e2.v);
        if (nms_valid === 1'b1) obs_valid++;
        if (frame_done === 1'b1) obs_done++;
        if (e2.v) begin
            chk("data", nms_data, e2.data);
            chk("col", col_idx, e2.col);
            chk("row", row_idx, e2.row);
            chk("done", frame_done, e2.done);
        end else begin
            chk("done_idle", frame_done, 0);
        end
        win_valid = v;
        dir_in    = d;
        for (int i = 0; i < 9; i++) w[i] = p[i];
        n = ezero;
        if (v) begin
            border = (bcol < K - 1) || (brow == 0) || (brow == LASTROW);
            n.v    = 1'b1;
            n.data = model(d, p, border);
            n.col  = bcol;
            n.row  = brow;
            n.done = (brow == LASTROW) && (bcol == W - 1);
            if (bcol == W - 1) begin
                bcol = 0;
                brow = (brow == LASTROW) ? 0 : brow + 1;
            end else begin
                bcol = bcol + 1;
            end
        end
        e2 = e1;
        e1 = n;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, z);
    endtask

    task automatic rnd_win(output logic [15:0] p [9]);
        for (int i = 0; i < 9; i++) p[i] = 16'($urandom_range(0, 255));
    endtask

    task automatic goto(input int r, input int c);
        int guard = 0;
        while (!(brow == r && bcol == c) && guard < 1000) begin
            step(1'b1, 2'd0, z);
            guard++;
        end
        chk("goto_bound", (guard < 1000), 1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        win_valid = 1'b0;
        #1;
        chk("rst_valid", nms_valid, 0);
        chk("rst_data", nms_data, 0);
        chk("rst_col", col_idx, 0);
        chk("rst_row", row_idx, 0);
        chk("rst_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        e1 = ezero;
        e2 = ezero;
        bcol = 0;
        brow = 0;
    endtask

    initial begin
        ezero = '{v: 1'b0, data: 16'd0, col: 0, row: 0, done: 1'b0};
        e1 = ezero;
        e2 = ezero;
        bcol = 0;
        brow = 0;
        for (int i = 0; i < 9; i++) begin
            z[i] = 16'd0;
            w[i] = 16'd0;
        end

        vecs[0]  = '{0, 5,  2'd1, '{0, 0, 0, 0, 200, 0, 0, 0, 0},   16'd0};
        vecs[1]  = '{5, 10, 2'd0, '{0, 0, 0, 50, 80, 60, 0, 0, 0},  16'd80};
        vecs[2]  = '{5, 11, 2'd0, '{0, 0, 0, 50, 80, 90, 0, 0, 0},  16'd0};
        vecs[3]  = '{5, 12, 2'd2, '{0, 70, 0, 0, 70, 0, 0, 70, 0},  16'd0};
        vecs[4]  = '{5, 13, 2'd2, '{0, 70, 0, 0, 70, 0, 0, 69, 0},  16'd70};
        vecs[5]  = '{5, 14, 2'd3, '{40, 0, 0, 0, 40, 0, 0, 0, 10},  16'd40};
        vecs[6]  = '{6, 2,  2'd1, '{0, 0, 0, 0, 15, 0, 0, 0, 0},    16'd0};
        vecs[7]  = '{6, 3,  2'd1, '{0, 0, 19, 0, 25, 0, 10, 0, 0},  16'd25};
        vecs[8]  = '{7, 5,  2'd2, '{0, 0, 0, 0, 200, 0, 0, 0, 0},   16'd0};
        vecs[9]  = '{1, 0,  2'd0, '{0, 0, 0, 0, 200, 0, 0, 0, 0},   16'd0};
        vecs[10] = '{1, 1,  2'd3, '{0, 0, 0, 0, 200, 0, 0, 0, 0},   16'd0};
        vecs[11] = '{1, 2,  2'd0, '{0, 0, 0, 0, 200, 0, 0, 0, 0},   16'd200};

        #2;
        do_reset();

        // Reset mid-frame, then restart from row 0 col 0.
        for (int i = 0; i < 100; i++) begin
            rnd_win(rw);
            step(1'b1, 2'($urandom_range(0, 3)), rw);
        end
        do_reset();
        step(1'b1, 2'd0, z);
        idle();
        chk("post_rst_valid", nms_valid, 1);
        chk("post_rst_col", col_idx, 0);
        chk("post_rst_row", row_idx, 0);
        idle();

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            goto(vecs[i].row, vecs[i].col);
            step(1'b1, vecs[i].dir, vecs[i].p);
            idle();
            chk("tbl_valid", nms_valid, 1);
            chk($sformatf("tbl_data_%0d", i), nms_data, vecs[i].exp);
            idle();
        end

        // Full frame with a gap every 7th cycle.
        do_reset();
        obs_valid = 0;
        obs_done  = 0;
        begin
            int cyc = 0;
            int sent = 0;
            while (sent < W * (D - 2)) begin
                if (cyc % 7 == 6) begin
                    idle();
                end else begin
                    rnd_win(rw);
                    step(1'b1, 2'($urandom_range(0, 3)), rw);
                    sent++;
                end
                cyc++;
            end
        end
        idle();
        idle();
        chk("frame_valid_count", obs_valid, W * (D - 2));
        chk("frame_done_count", obs_done, 1);
        step(1'b1, 2'd0, z);
        idle();
        chk("wrap_col", col_idx, 0);
        chk("wrap_row", row_idx, 0);
        idle();

        // Random compare against the model.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle();
            end else begin
                rnd_win(rw);
                step(1'b1, 2'($urandom_range(0, 3)), rw);
            end
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
